// File: rtl/fifo8x9_ctrl.sv
// rtl/fifo8x9_ctrl.sv - Control for an external 8x9 FIFO memory with a registered output word.
// Tracks occupancy and shadow pointers; memory pointers are cleared rather than incremented past 7.
module fifo8x9_ctrl #(
  parameter int unsigned AFULL_LVL = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [8:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [8:0] out_data,
  output logic [3:0] count,
  output logic       full,
  output logic       empty,
  output logic       almost_full,
  output logic [3:0] peak,
  output logic       mem_wren,
  output logic       mem_wr_inc,
  output logic       mem_wr_ptr_clr,
  output logic       mem_rden,
  output logic       mem_rd_inc,
  output logic       mem_rd_ptr_clr,
  output logic [8:0] mem_din,
  input  logic [8:0] mem_dout
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] mem_cnt_q, mem_cnt_d;
  logic [2:0] wr_idx_q, wr_idx_d;
  logic [2:0] rd_idx_q, rd_idx_d;
  logic       out_valid_q, out_valid_d;
  logic [8:0] out_data_q, out_data_d;
  logic [3:0] peak_q, peak_d;
  logic [3:0] count_d;

  logic run;
  logic push;
  logic fetch;
  logic pop;

  assign run      = (state_q == ST_RUN);
  assign in_ready = run && (mem_cnt_q < 4'd8);

  // A flush cycle discards any handshake presented alongside it.
  assign push  = run && !flush && in_valid && in_ready;
  assign fetch = run && !flush && (mem_cnt_q != 4'd0) && (!out_valid_q || out_ready);
  assign pop   = run && !flush && out_valid_q && out_ready;

  assign mem_wren       = push;
  assign mem_wr_inc     = push && (wr_idx_q != 3'd7);
  assign mem_wr_ptr_clr = !run || (push && (wr_idx_q == 3'd7));
  assign mem_rden       = fetch;
  assign mem_rd_inc     = fetch && (rd_idx_q != 3'd7);
  assign mem_rd_ptr_clr = !run || (fetch && (rd_idx_q == 3'd7));
  assign mem_din        = in_data;

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign count       = mem_cnt_q + {3'd0, out_valid_q};
  assign full        = (mem_cnt_q == 4'd8);
  assign empty       = (count == 4'd0);
  assign almost_full = (32'(count) >= AFULL_LVL);
  assign peak        = peak_q;

  always_comb begin
    state_d     = state_q;
    mem_cnt_d   = mem_cnt_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    peak_d      = peak_q;
    count_d     = 4'd0;

    case (state_q)
      ST_CLEAR: begin
        state_d  = ST_RUN;
        wr_idx_d = 3'd0;
        rd_idx_d = 3'd0;
      end
      ST_RUN: begin
        if (flush) begin
          state_d     = ST_CLEAR;
          mem_cnt_d   = 4'd0;
          wr_idx_d    = 3'd0;
          rd_idx_d    = 3'd0;
          out_valid_d = 1'b0;
          out_data_d  = 9'd0;
          peak_d      = 4'd0;
        end else begin
          mem_cnt_d = mem_cnt_q + {3'd0, push} - {3'd0, fetch};
          if (push) begin
            wr_idx_d = wr_idx_q + 3'd1;
          end
          if (fetch) begin
            rd_idx_d    = rd_idx_q + 3'd1;
            out_valid_d = 1'b1;
            out_data_d  = mem_dout;
          end else if (pop) begin
            out_valid_d = 1'b0;
          end
          count_d = mem_cnt_d + {3'd0, out_valid_d};
          if (count_d > peak_q) begin
            peak_d = count_d;
          end
        end
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_CLEAR;
      mem_cnt_q   <= 4'd0;
      wr_idx_q    <= 3'd0;
      rd_idx_q    <= 3'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 9'd0;
      peak_q      <= 4'd0;
    end else begin
      state_q     <= state_d;
      mem_cnt_q   <= mem_cnt_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      peak_q      <= peak_d;
    end
  end

endmodule

// File: tb/tb_fifo8x9_ctrl.sv
// tb/tb_fifo8x9_ctrl.sv - Directed bench for fifo8x9_ctrl with a queue-level reference model.
// Includes a behavioural 8x9 memory driven by the controller's pointer controls.
module tb_fifo8x9_ctrl;

  logic       clk = 1'b0;
  logic       rst, flush, in_valid, out_ready;
  logic [8:0] in_data;
  logic       in_ready, out_valid;
  logic [8:0] out_data;
  logic [3:0] count, peak;
  logic       full, empty, almost_full;
  logic       mem_wren, mem_wr_inc, mem_wr_ptr_clr;
  logic       mem_rden, mem_rd_inc, mem_rd_ptr_clr;
  logic [8:0] mem_din, mem_dout;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  fifo8x9_ctrl #(.AFULL_LVL(6)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .full(full), .empty(empty), .almost_full(almost_full), .peak(peak),
    .mem_wren(mem_wren), .mem_wr_inc(mem_wr_inc), .mem_wr_ptr_clr(mem_wr_ptr_clr),
    .mem_rden(mem_rden), .mem_rd_inc(mem_rd_inc), .mem_rd_ptr_clr(mem_rd_ptr_clr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural memory: pointer actions sampled mid-cycle, applied at the edge.
  logic [8:0] mem [8];
  logic [2:0] wptr = 3'd0, rptr = 3'd0;
  logic       c_wren, c_winc, c_wclr, c_rinc, c_rclr;
  logic [8:0] c_din;
  assign mem_dout = mem[rptr];

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 9'd0;
    c_wren = 1'b0; c_winc = 1'b0; c_wclr = 1'b0; c_rinc = 1'b0; c_rclr = 1'b0; c_din = 9'd0;
  end

  always @(posedge clk) begin
    if (c_wren) mem[wptr] <= c_din;
    if (c_wclr) wptr <= 3'd0; else if (c_winc) wptr <= wptr + 3'd1;
    if (c_rclr) rptr <= 3'd0; else if (c_rinc) rptr <= rptr + 3'd1;
  end

  // Reference model: queue of words held in memory plus the output register.
  bit         m_live = 1'b0;
  bit         m_run = 1'b0;
  logic [8:0] mq[$];
  bit         m_ov = 1'b0;
  logic [8:0] m_od = 9'd0;
  int         m_peak = 0;
  int         m_wr_n = 0, m_rd_n = 0;

  always @(posedge clk) begin
    bit p, f;
    if (rst) begin
      m_live = 1'b1; m_run = 1'b0; mq.delete(); m_ov = 1'b0; m_od = 9'd0;
      m_peak = 0; m_wr_n = 0; m_rd_n = 0;
    end else if (m_live) begin
      if (!m_run) begin
        m_run = 1'b1; m_wr_n = 0; m_rd_n = 0;
      end else if (flush) begin
        m_run = 1'b0; mq.delete(); m_ov = 1'b0; m_peak = 0;
      end else begin
        p = in_valid && (mq.size() < 8);
        f = (mq.size() > 0) && (!m_ov || out_ready);
        if (f) begin
          m_od = mq.pop_front(); m_ov = 1'b1; m_rd_n++;
        end else if (m_ov && out_ready) begin
          m_ov = 1'b0;
        end
        if (p) begin
          mq.push_back(in_data); m_wr_n++;
        end
        if (mq.size() + int'(m_ov) > m_peak) m_peak = mq.size() + int'(m_ov);
      end
    end
  end

  bit cnt_en = 1'b0;
  int wclr_n = 0, rclr_n = 0;

  always @(negedge clk) begin
    int  cnt;
    bit  e_push, e_fetch;
    c_wren = mem_wren; c_winc = mem_wr_inc; c_wclr = mem_wr_ptr_clr;
    c_rinc = mem_rd_inc; c_rclr = mem_rd_ptr_clr; c_din = mem_din;
    if (m_live) begin
      cnt     = mq.size() + int'(m_ov);
      e_push  = m_run && !flush && in_valid && (mq.size() < 8);
      e_fetch = m_run && !flush && (mq.size() > 0) && (!m_ov || out_ready);
      chk("in_ready", int'(in_ready), int'(m_run && (mq.size() < 8)));
      chk("out_valid", int'(out_valid), int'(m_ov));
      if (m_ov) chk("out_data", int'(out_data), int'(m_od));
      chk("count", int'(count), cnt);
      chk("full", int'(full), int'(mq.size() == 8));
      chk("empty", int'(empty), int'(cnt == 0));
      chk("almost_full", int'(almost_full), int'(cnt >= 6));
      chk("peak", int'(peak), m_peak);
      chk("mem_din", int'(mem_din), int'(in_data));
      if (!rst) begin
        chk("mem_wren", int'(mem_wren), int'(e_push));
        chk("mem_rden", int'(mem_rden), int'(e_fetch));
        chk("mem_wr_inc", int'(mem_wr_inc), int'(e_push && (m_wr_n % 8 != 7)));
        chk("mem_wr_ptr_clr", int'(mem_wr_ptr_clr), int'(!m_run || (e_push && (m_wr_n % 8 == 7))));
        chk("mem_rd_inc", int'(mem_rd_inc), int'(e_fetch && (m_rd_n % 8 != 7)));
        chk("mem_rd_ptr_clr", int'(mem_rd_ptr_clr), int'(!m_run || (e_fetch && (m_rd_n % 8 == 7))));
        if (mem_wr_inc) chk("wr_ptr_past_7", int'(wptr == 3'd7), 0);
        if (mem_rd_inc) chk("rd_ptr_past_7", int'(rptr == 3'd7), 0);
      end
      if (cnt_en && mem_wren && mem_wr_ptr_clr) wclr_n++;
      if (cnt_en && mem_rden && mem_rd_ptr_clr) rclr_n++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [8:0] d);
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 20 && !in_ready; i++) step();
    chk("push_accept_timeout", int'(in_ready), 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 60 && !empty; i++) step();
    chk("drain_timeout", int'(empty), 1);
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 9'd0;
    step(); step(); step();
    rst = 1'b0;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_peak", int'(peak), 0);
    chk("rst_wr_clr", int'(mem_wr_ptr_clr), 1);
    chk("rst_rd_clr", int'(mem_rd_ptr_clr), 1);
    step();
    chk("run_in_ready", int'(in_ready), 1);

    // Single word: no bypass, output register loads one edge after acceptance.
    push1(9'h1A5);
    chk("no_bypass_valid", int'(out_valid), 0);
    step();
    chk("first_valid", int'(out_valid), 1);
    chk("first_data", int'(out_data), 9'h1A5);
    chk("first_count", int'(count), 1);
    drain();

    // Fill to nine words with the output stalled.
    for (int i = 0; i < 9; i++) push1(9'h100 + 9'(i));
    chk("fill_count", int'(count), 9);
    chk("fill_full", int'(full), 1);
    chk("fill_afull", int'(almost_full), 1);
    chk("fill_in_ready", int'(in_ready), 0);
    chk("fill_head", int'(out_data), 9'h100);
    chk("fill_peak", int'(peak), 9);
    in_valid = 1'b1; in_data = 9'h1FF;
    step(); step(); step();
    in_valid = 1'b0;
    chk("refused_count", int'(count), 9);
    drain();

    // Streaming 20 words from freshly cleared pointers.
    flush = 1'b1; step(); flush = 1'b0; step();
    cnt_en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) push1(9'h040 + 9'(i));
    drain();
    cnt_en = 1'b0;
    chk("stream_wr_clr_pulses", wclr_n, 2);
    chk("stream_rd_clr_pulses", rclr_n, 2);

    // Simultaneous push and pop at count 5.
    for (int i = 0; i < 5; i++) push1(9'h150 + 9'(i));
    chk("five_count", int'(count), 5);
    in_valid = 1'b1; in_data = 9'h155; out_ready = 1'b1;
    #1;
    chk("both_wren", int'(mem_wren), 1);
    chk("both_rden", int'(mem_rden), 1);
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("both_count", int'(count), 5);

    // Flush at count 4, with a push and pop offered in the same cycle.
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("pre_flush_count", int'(count), 4);
    flush = 1'b1; in_valid = 1'b1; in_data = 9'h0AA; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("flush_count", int'(count), 0);
    chk("flush_peak", int'(peak), 0);
    chk("flush_valid", int'(out_valid), 0);
    chk("flush_in_ready", int'(in_ready), 0);
    chk("flush_wr_clr", int'(mem_wr_ptr_clr), 1);
    chk("flush_rd_clr", int'(mem_rd_ptr_clr), 1);
    step();
    push1(9'h0FF);
    step();
    chk("post_flush_valid", int'(out_valid), 1);
    chk("post_flush_data", int'(out_data), 9'h0FF);
    drain();

    // Reset mid-stream at count 7 overrides flush, push and pop.
    for (int i = 0; i < 7; i++) push1(9'h170 + 9'(i));
    chk("seven_count", int'(count), 7);
    rst = 1'b1; flush = 1'b1; in_valid = 1'b1; in_data = 9'h1EE; out_ready = 1'b1;
    step();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("midrst_count", int'(count), 0);
    chk("midrst_empty", int'(empty), 1);
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_data", int'(out_data), 0);
    chk("midrst_in_ready", int'(in_ready), 0);
    step();
    chk("midrst_run", int'(in_ready), 1);
    push1(9'h123);
    step();
    chk("midrst_next_data", int'(out_data), 9'h123);
    drain();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
